// File: rtl/text_line_sched.sv
// text_line_sched: per-scanline text fetch and pixel serialiser for an 8x8 font ROM.
// On each line_start it picks the text row (row 0 wins on overlap) covering the
// upcoming scanline. It fetches NCHARS glyph rows into a line buffer through a
// 2-stage pipe (string source, then font ROM). During active video it
// serialises the buffer into a registered text_pixel.
// Optional feature: define TEXT_SHADOW_EN to build the drop-shadow output;
// otherwise text_shadow is tied low.
module text_line_sched #(
  parameter int NCHARS     = 16,
  parameter int SCALE_LOG2 = 1,
  parameter int ROW0_Y     = 8,
  parameter int ROW1_Y     = 456,
  parameter int X0         = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      line_start,
  input  logic [9:0]                line_y,
  input  logic [9:0]                pixel_x,
  input  logic                      pixel_valid,
  output logic                      str_sel,
  output logic [$clog2(NCHARS)-1:0] char_idx,
  input  logic [7:0]                char_code,
  output logic [7:0]                font_char,
  output logic [2:0]                font_row,
  input  logic [7:0]                font_bitmap,
  output logic                      busy,
  output logic                      text_pixel,
  output logic                      text_shadow
);

  localparam int IDXW  = $clog2(NCHARS);
  localparam int ROW_H = 8 << SCALE_LOG2;
  localparam int TXT_W = (NCHARS * 8) << SCALE_LOG2;

  localparam logic [10:0] R0_LO = 11'(ROW0_Y);
  localparam logic [10:0] R0_HI = 11'(ROW0_Y + ROW_H);
  localparam logic [10:0] R1_LO = 11'(ROW1_Y);
  localparam logic [10:0] R1_HI = 11'(ROW1_Y + ROW_H);
  localparam logic [10:0] X_LO  = 11'(X0);
  localparam logic [10:0] X_HI  = 11'(X0 + TXT_W);

  localparam logic [IDXW:0]   K_LAST    = (IDXW+1)'(NCHARS);
  localparam logic [IDXW:0]   K_PRELAST = (IDXW+1)'(NCHARS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;

  state_t            state_q;
  logic              busy_q;
  logic              valid_q;
  logic              str_sel_q;
  logic [2:0]        font_row_q;
  logic [IDXW:0]     k_q;
  logic [IDXW-1:0]   char_idx_q;
  logic [7:0]        code_q;
  logic              text_pixel_q;
  logic [7:0]        buf_q [NCHARS];

  // Scanline decode: which text row covers line_y and which glyph row it needs.
  logic [10:0] ly_ext, off0, off1;
  logic        hit0, hit1, hit_any;
  logic [2:0]  font_row_d;

  assign ly_ext     = {1'b0, line_y};
  assign hit0       = (ly_ext >= R0_LO) && (ly_ext < R0_HI);
  assign hit1       = (ly_ext >= R1_LO) && (ly_ext < R1_HI);
  assign hit_any    = hit0 || hit1;
  assign off0       = ly_ext - R0_LO;
  assign off1       = ly_ext - R1_LO;
  assign font_row_d = hit0 ? off0[SCALE_LOG2+2:SCALE_LOG2] : off1[SCALE_LOG2+2:SCALE_LOG2];

  // Pixel decode: character slot and font column under pixel_x.
  logic [10:0]     px_ext, dx;
  logic            in_range;
  logic [IDXW-1:0] ch;
  logic [2:0]      col;
  logic            cur_bit;
  logic            pix_en;

  assign px_ext   = {1'b0, pixel_x};
  assign in_range = (px_ext >= X_LO) && (px_ext < X_HI);
  assign dx       = px_ext - X_LO;
  assign ch       = dx[3+SCALE_LOG2+IDXW-1:3+SCALE_LOG2];
  assign col      = dx[SCALE_LOG2+2:SCALE_LOG2];
  assign cur_bit  = buf_q[ch][3'd7 - col];
  assign pix_en   = valid_q && (state_q == SHOW) && pixel_valid && in_range;

  // Buffer write index lags k by one because the ROM lookup is stage 2.
  logic [IDXW:0] wr_idx;
  assign wr_idx = k_q - 1'b1;

  logic unused_bits;
  assign unused_bits = ^{off0, off1, dx, wr_idx};

  // Control FSM: line_start always wins, then the fetch pipe advances k.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      str_sel_q  <= 1'b0;
      font_row_q <= 3'd0;
      k_q        <= '0;
      char_idx_q <= '0;
      code_q     <= 8'd0;
    end else if (line_start) begin
      valid_q <= 1'b0;
      if (hit_any) begin
        state_q    <= FETCH;
        busy_q     <= 1'b1;
        str_sel_q  <= ~hit0;
        font_row_q <= font_row_d;
        k_q        <= '0;
        char_idx_q <= '0;
      end else begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        FETCH: begin
          // stage 1: capture the code for index k
          if (k_q != K_LAST) begin
            code_q <= char_code;
            if (k_q != K_PRELAST) char_idx_q <= char_idx_q + 1'b1;
          end
          if (k_q == K_LAST) begin
            state_q <= SHOW;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
          k_q <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stage 2: the ROM bitmap for code_q lands in buffer slot k-1.
  always_ff @(posedge clk) begin
    if ((state_q == FETCH) && !line_start && (k_q != '0))
      buf_q[wr_idx[IDXW-1:0]] <= font_bitmap;
  end

  // Pixel output register: one cycle behind pixel_x/pixel_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) text_pixel_q <= 1'b0;
    else       text_pixel_q <= pix_en & cur_bit;
  end

`ifdef TEXT_SHADOW_EN
  logic            left_bit;
  logic            text_shadow_q;
  logic [2:0]      col_m1;
  logic [IDXW-1:0] ch_m1;

  assign col_m1 = col - 3'd1;
  assign ch_m1  = ch - 1'b1;

  // Font column to the left of the current one, crossing into the previous char.
  always_comb begin
    left_bit = 1'b0;
    if (col != 3'd0)      left_bit = buf_q[ch][3'd7 - col_m1];
    else if (ch != '0)    left_bit = buf_q[ch_m1][0];
  end

  // Shadow register: same latency as text_pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) text_shadow_q <= 1'b0;
    else       text_shadow_q <= pix_en & ~cur_bit & left_bit;
  end

  assign text_shadow = text_shadow_q;
`else
  assign text_shadow = 1'b0;
`endif

  assign busy       = busy_q;
  assign str_sel    = str_sel_q;
  assign font_row   = font_row_q;
  assign char_idx   = char_idx_q;
  assign font_char  = code_q;
  assign text_pixel = text_pixel_q;

endmodule

// File: doc/text_line_sched.md
# text_line_sched

Scanline scheduler for the 8x8 font ROM. On each line start it decides which on-screen text row (if any) covers the upcoming scanline, then fetches that row's character codes from the string source. It looks up one glyph row per character through the single combinational font ROM port and stores the bitmaps in a line buffer. During active video it serialises the buffer into a registered `text_pixel` for the VGA colour mux.

## Interface
Parameters:
- `NCHARS`, 16: characters per text row; power of two.
- `SCALE_LOG2`, 1: glyph magnification, 2^SCALE_LOG2 pixels per font bit in x and y.
- `ROW0_Y`, 8: top scanline of text row 0 (score line).
- `ROW1_Y`, 456: top scanline of text row 1 (status message).
- `X0`, 64: first pixel column of both text rows.

Ports:
- `clk`  in  1  pixel clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `line_start`  in  1  one-cycle pulse at start of horizontal blank; announces `line_y`.
- `line_y`  in  10  scanline about to be displayed; sampled on `line_start`.
- `pixel_x`  in  10  current pixel column.
- `pixel_valid`  in  1  active-video qualifier.
- `str_sel`  out  1  text row being fetched (0 or 1).
- `char_idx`  out  log2(NCHARS)  character index requested from string source.
- `char_code`  in  8  ASCII code for (`str_sel`, `char_idx`); combinational, same cycle.
- `font_char`  out  8  to font ROM character address.
- `font_row`  out  3  to font ROM row address.
- `font_bitmap`  in  8  from font ROM; combinational, same cycle; MSB = leftmost pixel.
- `busy`  out  1  fetch in progress.
- `text_pixel`  out  1  text foreground at the pixel presented one cycle earlier.
- `text_shadow`  out  1  drop-shadow pixel (see Configuration).

## Operation
- Text row n covers `line_y` in [ROWn_Y, ROWn_Y + 8·2^SCALE_LOG2).
- If both rows cover the line, row 0 wins.
- Glyph row: `font_row` = (`line_y` − ROWn_Y) >> SCALE_LOG2, latched on `line_start`.
- State machine: IDLE, FETCH, SHOW.
  - IDLE: `busy`=0; the buffer-valid flag is 0.
  - `line_start` with a covered line: go to FETCH. Latch `str_sel` and `font_row`, set k=0, clear the valid flag.
  - `line_start` with no covered line: go to or stay in IDLE with the valid flag cleared.
  - FETCH is a 2-stage pipe:
    - Stage 1: drive `char_idx`=k and register `char_code` into the code register.
    - Stage 2: drive `font_char` from the code register and write `font_bitmap` to buffer[k−1].
    - k runs 0..NCHARS. On the cycle the last entry is written, go to SHOW and set the valid flag.
  - SHOW: serialise the buffer. Leave SHOW only on `line_start` (to FETCH or IDLE).
- Pixel mapping in SHOW: d = `pixel_x` − X0. When 0 ≤ d < NCHARS·8·2^SCALE_LOG2:
  - char = d >> (3+SCALE_LOG2)
  - bit = 7 − ((d >> SCALE_LOG2) & 7)
  - `text_pixel` next cycle = buffer[char][bit].
- Outside that range, or with `pixel_valid`=0, or when not in SHOW, `text_pixel` next cycle = 0.
- `line_start` during FETCH aborts the current fetch and restarts with the newly sampled `line_y`. No partial SHOW occurs.
- `char_idx`, `font_char` and `font_row` hold their last values outside FETCH.

## Timing
- Reset values: state IDLE, `busy`=0, `text_pixel`=0, `text_shadow`=0, `str_sel`=0, `char_idx`=0, `font_char`=0, `font_row`=0, valid flag 0.
- Buffer contents are don't-care after reset; they are masked by the valid flag.
- Fetch latency: `busy` rises the cycle after `line_start` and stays high for exactly NCHARS+1 cycles. SHOW is entered on the following cycle.
- The fetch fits in any hblank ≥ NCHARS+2 cycles; the 640x480 hblank of 160 cycles is sufficient.
- Pixel path latency is exactly 1 cycle from `pixel_x`/`pixel_valid` to `text_pixel`.
- Reset asserted mid-FETCH returns to IDLE immediately (asynchronously). The next `line_start` starts a clean fetch.

## Configuration
- `TEXT_SHADOW_EN` defined:
  - `text_shadow` is registered with 1-cycle latency, like `text_pixel`.
  - It is 1 when the current text bit is 0 and the bit one font column to the left in the same glyph row is 1.
  - Across a character boundary, "to the left" is the previous character's bit 0.
  - The first column of char 0 never shadows.
  - The shadow spans 2^SCALE_LOG2 pixels.
- Not defined: `text_shadow` is tied to 0 and no shadow logic is synthesised.

## Test plan
- Defaults; string source returns "SCORE:0123" padded with spaces; `line_start` with `line_y`=8. Required: `busy` high for 17 cycles, `font_row`=0, `font_char` sequence 0x53,0x43,0x4F… in stage 2.
- Same setup with `line_y`=11. Required: `font_row`=1. Sweep `pixel_x` 64..319 and compare `text_pixel` against the golden font, each bit doubled in x, 1-cycle latency.
- `line_y`=200 (no row covered), then sweep. Required: `busy` stays 0 and `text_pixel` stays 0 for all `pixel_x`.
- `line_start` pulsed again 5 cycles into a fetch, with `line_y`=460. Required: fetch restarts with `str_sel`=1 and `font_row`=2; `busy` stays high 17 cycles from the second pulse.
- Reset asserted at fetch cycle 8 and `pixel_x` swept. Required: all outputs return to reset values immediately and `text_pixel`=0 until a new fetch completes.
- `TEXT_SHADOW_EN` with char '1' (row 0 = 00110000). Required: `text_shadow`=1 only at font bit 3, i.e. 2 pixels right of the glyph pixels; `text_shadow`=0 everywhere in a build without the macro.
